rx_serial_7o1: RTL
==================

// Module: rx_serial_7O1
// PURPOSE
//   Asynchronous serial receiver for the 7O1 frame format: idle 1, start 0, 7 data bits
//   (LSB first), odd parity bit, 1 stop bit. It is the receive-side counterpart of the
//   team's 7O1 transmitter. A 2-FF synchronizer, a bit timer and a control FSM recover
//   the ASCII character, check parity and stop bit, and present the result with a
//   pronto pulse and a held tem_dado flag.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200); must be >= 4
// PORTS
//   clock        in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high reset
//   dado_serial  in   1  serial line (asynchronous to clock; idles at 1)
//   limpa        in   1  clears tem_dado (synchronous)
//   dados_ascii  out  7  last correctly framed character
//   paridade_ok  out  1  1 = last character had odd parity (data + parity bit)
//   pronto       out  1  1-cycle pulse: new character loaded
//   tem_dado     out  1  set with pronto, held until limpa
//   erro_frame   out  1  1-cycle pulse: stop bit sampled as 0
//   db_estado    out  4  current FSM state code (debug)
// BEHAVIOUR
// - Reset values:
//   - dados_ascii=0, paridade_ok=0, pronto=0, tem_dado=0, erro_frame=0, db_estado=0.
//   - Synchronizer FFs=1, timer=0, bit count=0, shift register=0.
//   - Reset mid-frame aborts the frame with no pronto and no erro_frame; the receiver
//     then restarts in REPOUSO.
// - Synchronizer: 2 FFs; FSM sees dado_serial 2 cycles late (rx_s).
// - Timer: width $clog2(CLKS_PER_BIT), zeroed on every state change, +1 per cycle otherwise.
//   - HALF = CLKS_PER_BIT/2 (integer division).
// - FSM (db_estado code):
//   - REPOUSO (0): timer held 0; rx_s==0 -> INICIO.
//   - INICIO (1): when timer==HALF-1, sample rx_s.
//     - 0 -> DADOS.
//     - 1 -> REPOUSO (glitch rejected, nothing reported).
//   - DADOS (2): when timer==CLKS_PER_BIT-1, sample rx_s into shift reg bit[k], k=0..6
//     (LSB first), k++, timer zeroed.
//     - After the 7th sample -> PARIDADE.
//   - PARIDADE (3): when timer==CLKS_PER_BIT-1, store parity bit -> PARADA.
//   - PARADA (4): when timer==CLKS_PER_BIT-1, sample rx_s.
//     - 1 -> FIM.
//     - 0 -> erro_frame=1 for 1 cycle -> ESPERA (5); dados_ascii, paridade_ok and
//       tem_dado unchanged.
//   - ESPERA (5): stays until rx_s==1 -> REPOUSO.
//   - FIM (6): single cycle.
//     - Load dados_ascii=shift reg and paridade_ok = ^{data,parity} (1 = odd count).
//     - pronto=1, tem_dado=1 -> REPOUSO.
// - All samples fall mid-bit.
// - Latency: pronto rises 2 + HALF + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling
//   edge of dado_serial at the pin.
// - Parity error does not block delivery: data loaded, pronto pulses, paridade_ok=0.
// - tem_dado / limpa:
//   - limpa in the same cycle as FIM: set wins, tem_dado=1.
//   - New frame while tem_dado=1: dados_ascii overwritten, tem_dado stays 1.
// - Back-to-back frames (next start bit right after stop) are received. REPOUSO is
//   re-entered before the stop bit ends, so the next falling edge is caught.
// - Line held at 0 (break) is handled as follows: one erro_frame pulse, then held in
//   ESPERA until line returns to 1.
// - Outputs are registered; no combinational path from dado_serial.
// TESTING  (bench uses CLKS_PER_BIT=8)
// 1. Frame 0x41 (data 1000001, parity 1, stop 1) -> dados_ascii=7'h41, paridade_ok=1,
//    pronto 1 cycle, tem_dado=1, db_estado returns 0.
// 2. Frame 0x41 with parity bit 0 -> dados_ascii=7'h41, paridade_ok=0, pronto pulses.
// 3. Line low 3 cycles then high -> INICIO->REPOUSO, no pronto, no erro_frame.
// 4. Frame 0x23 with stop=0, line held low 20 cycles, then frame 0x7F (parity 0):
//    - erro_frame one pulse; tem_dado/dados_ascii unchanged; db_estado=5 while low.
//    - Then dados_ascii=7'h7F, paridade_ok=1.
// 5. Back-to-back 0x30 then 0x55 (both parity 1), no idle gap:
//    - Two pronto pulses, values 7'h30 then 7'h55.
//    - limpa between them clears tem_dado; limpa coincident with the second FIM leaves
//      tem_dado=1.
// 6. reset asserted during DADOS (bit 3) -> all outputs 0 immediately; following frame
//    0x41 is received correctly.

Source files
------------

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: 2-FF synchronizer, bit timer and control FSM.
// The recovered character, parity status and framing error come out as registered signals.
module rx_serial_7o1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       limpa,
  output logic [6:0] dados_ascii,
  output logic       paridade_ok,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_frame,
  output logic [3:0] db_estado
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    REPOUSO  = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    ESPERA   = 4'd5,
    FIM      = 4'd6
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            erro_d;
  logic [6:0]      data_q;
  logic            par_ok_q, pronto_q, tem_q, erro_q;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    erro_d    = 1'b0;
    case (state_q)
      REPOUSO: begin
        timer_d = '0;
        if (!rx_s) state_d = INICIO;
      end
      INICIO: begin
        if (timer_q == HALF_M1) state_d = rx_s ? REPOUSO : DADOS;
      end
      DADOS: begin
        if (timer_q == LAST) begin
          shift_d[bit_cnt_q] = rx_s;
          timer_d            = '0;
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_d = 3'd0;
            state_d   = PARIDADE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARIDADE: begin
        if (timer_q == LAST) begin
          par_d   = rx_s;
          state_d = PARADA;
        end
      end
      PARADA: begin
        if (timer_q == LAST) begin
          state_d = rx_s ? FIM : ESPERA;
          erro_d  = ~rx_s;
        end
      end
      ESPERA: begin
        timer_d = '0;
        if (rx_s) state_d = REPOUSO;
      end
      FIM:     state_d = REPOUSO;
      default: state_d = REPOUSO;
    endcase
    // Every state change restarts the bit timer from zero.
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= REPOUSO;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      timer_q   <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      par_q     <= 1'b0;
      data_q    <= 7'd0;
      par_ok_q  <= 1'b0;
      pronto_q  <= 1'b0;
      tem_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      sync1_q   <= dado_serial;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      pronto_q  <= (state_q == FIM);
      erro_q    <= erro_d;
      // Loading at the end of FIM lets a coincident limpa lose to the set.
      if (state_q == FIM) begin
        data_q   <= shift_q;
        par_ok_q <= ^{shift_q, par_q};
        tem_q    <= 1'b1;
      end else if (limpa) begin
        tem_q    <= 1'b0;
      end
    end
  end

  assign dados_ascii = data_q;
  assign paridade_ok = par_ok_q;
  assign pronto      = pronto_q;
  assign tem_dado    = tem_q;
  assign erro_frame  = erro_q;
  assign db_estado   = state_q;

endmodule
